// File: rtl/spi_minion_pkg.sv
// spi_minion_pkg: shared types and constants for the SPI minion frontend.
//   state_t     - frame FSM states (IDLE, SHIFT, COMMIT)
//   VAL_BIT_OFS - frame val bit index relative to PAYLOAD_NBITS
//   SPC_BIT_OFS - frame spc bit index relative to PAYLOAD_NBITS
//   cnt_width() - bit counter width for a given payload size
package spi_minion_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int VAL_BIT_OFS = 1;
    localparam int SPC_BIT_OFS = 0;

    // The counter saturates at n+3, so it must represent 0..n+3 inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 4);
    endfunction

endpackage

// File: rtl/spi_minion_sync.sv
// spi_minion_sync: pad-input synchronizer with edge pulses.
//   clk, reset : system clock, synchronous active-low reset
//   din        : asynchronous pad input
//   dout       : synchronized level (SYNC_STAGES flops deep, minimum 2)
//   rise, fall : registered one-cycle edge pulses, aligned with dout
module spi_minion_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Edges come from the last two stages, so each pulse lands on the
    // same cycle that dout takes its new value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            rise   <= sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
            fall   <= ~sync_q[SYNC_STAGES-2] & sync_q[SYNC_STAGES-1];
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_minion_frontend.sv
// spi_minion_frontend: SPI mode-0, MSB-first minion oversampled on clk.
// Frame = {val, spc, payload[PAYLOAD_NBITS-1:0]}.
//   clk, reset        : system clock, synchronous active-low reset
//   cs, sclk, mosi    : asynchronous SPI pad inputs (cs active low)
//   miso              : SPI data out
//   recv_msg/val/rdy  : received payload to the interconnect
//   send_msg/val/rdy  : payload from the interconnect; send_rdy is a dequeue pulse
//   minion_parity     : XOR of the last accepted receive payload
//   overflow          : sticky, a valid frame was dropped with the buffer full
//   frame_err_cnt     : saturating framing-error count, present only when
//                       SPI_MINION_FRAME_ERR_CNT_EN is defined
module spi_minion_frontend
    import spi_minion_pkg::*;
#(
    parameter int PAYLOAD_NBITS = 32,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cs,
    input  logic                     sclk,
    input  logic                     mosi,
    output logic                     miso,
    output logic [PAYLOAD_NBITS-1:0] recv_msg,
    output logic                     recv_val,
    input  logic                     recv_rdy,
    input  logic [PAYLOAD_NBITS-1:0] send_msg,
    input  logic                     send_val,
    output logic                     send_rdy,
    output logic                     minion_parity,
    output logic                     overflow
`ifdef SPI_MINION_FRAME_ERR_CNT_EN
    ,
    output logic [7:0]               frame_err_cnt
`endif
);

    localparam int N     = PAYLOAD_NBITS;
    localparam int FRAME = N + 2;
    localparam int CW    = cnt_width(N);
    localparam logic [CW-1:0] CNT_FULL = CW'(N + 2);
    localparam logic [CW-1:0] CNT_MAX  = CW'(N + 3);

    state_t state, state_n;

    logic cs_s, cs_rise, cs_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    logic [FRAME-1:0] shift_in;
    logic [FRAME-1:0] shift_out;
    logic [CW-1:0]    bit_cnt;
    logic             tx_val;
    logic             commit_ok;
    logic             frame_err;

    logic [N-1:0] rx_payload;
    logic         rx_val;
    logic         rx_spc;

    spi_minion_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(clk), .reset(reset), .din(cs),
        .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    spi_minion_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk(clk), .reset(reset), .din(sclk),
        .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_minion_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
        .clk(clk), .reset(reset), .din(mosi),
        .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{cs_s, sclk_s, mosi_rise, mosi_fall};

    assign rx_payload = shift_in[N-1:0];
    assign rx_val     = shift_in[N + VAL_BIT_OFS];
    assign rx_spc     = shift_in[N + SPC_BIT_OFS];
    assign miso       = shift_out[FRAME-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        commit_ok = 1'b0;
        frame_err = 1'b0;
        send_rdy  = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) state_n = SHIFT;
            end
            SHIFT: begin
                if (cs_rise) state_n = COMMIT;
            end
            COMMIT: begin
                state_n   = IDLE;
                commit_ok = (bit_cnt == CNT_FULL);
                frame_err = (bit_cnt != CNT_FULL);
                send_rdy  = commit_ok & tx_val & rx_spc;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_in      <= '0;
            shift_out     <= '0;
            bit_cnt       <= '0;
            tx_val        <= 1'b0;
            recv_msg      <= '0;
            recv_val      <= 1'b0;
            minion_parity <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            if (state == IDLE && cs_fall) begin
                shift_out <= {send_val, ~recv_val, send_msg};
                tx_val    <= send_val;
                shift_in  <= '0;
                bit_cnt   <= '0;
            end else if (state == SHIFT) begin
                if (sclk_rise) begin
                    shift_in <= {shift_in[FRAME-2:0], mosi_s};
                    if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
                end
                if (sclk_fall) shift_out <= {shift_out[FRAME-2:0], 1'b0};
            end

            if (recv_val && recv_rdy) recv_val <= 1'b0;

            // A same-cycle handshake frees the buffer before the commit
            // decides between accept and drop.
            if (commit_ok && rx_val) begin
                if (!recv_val || recv_rdy) begin
                    recv_msg      <= rx_payload;
                    recv_val      <= 1'b1;
                    minion_parity <= ^rx_payload;
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

`ifdef SPI_MINION_FRAME_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_err_cnt <= '0;
        end else if (frame_err && frame_err_cnt != 8'hFF) begin
            frame_err_cnt <= frame_err_cnt + 8'd1;
        end
    end
`else
    logic unused_frame_err;
    assign unused_frame_err = frame_err;
`endif

endmodule

// File: tb/tb_spi_minion_frontend.sv
// tb_spi_minion_frontend: directed bench for spi_minion_frontend with
// PAYLOAD_NBITS=32, SYNC_STAGES=2, sclk at clk/10.
module tb_spi_minion_frontend;

    localparam int N    = 32;
    localparam int F    = N + 2;
    localparam int HALF = 50;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         cs = 1'b1;
    logic         sclk = 1'b0;
    logic         mosi = 1'b0;
    logic         miso;
    logic [N-1:0] recv_msg;
    logic         recv_val;
    logic         recv_rdy = 1'b0;
    logic [N-1:0] send_msg = '0;
    logic         send_val = 1'b0;
    logic         send_rdy;
    logic         minion_parity;
    logic         overflow;
`ifdef SPI_MINION_FRAME_ERR_CNT_EN
    logic [7:0]   frame_err_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;
    int sr_cnt   = 0;
    logic [N-1:0] last_msg = '0;

    spi_minion_frontend #(.PAYLOAD_NBITS(N), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi),
        .miso(miso), .recv_msg(recv_msg), .recv_val(recv_val),
        .recv_rdy(recv_rdy), .send_msg(send_msg), .send_val(send_val),
        .send_rdy(send_rdy), .minion_parity(minion_parity),
        .overflow(overflow)
`ifdef SPI_MINION_FRAME_ERR_CNT_EN
        , .frame_err_cnt(frame_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Outputs are registered or decoded from registered state, so one
    // sample per negedge sees each single-cycle pulse exactly once.
    always @(negedge clk) begin
        if (recv_val && recv_rdy) begin
            hs_cnt   = hs_cnt + 1;
            last_msg = recv_msg;
        end
        if (send_rdy) sr_cnt = sr_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic spi_xfer(input logic [F-1:0] tx, input int nbits,
                            input bit raise_cs, output logic [F-1:0] rx);
        rx = '0;
        cs = 1'b0;
        #(2*HALF);
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[F-1-i];
            #HALF;
            sclk = 1'b1;
            rx[F-1-i] = miso;
            #HALF;
            sclk = 1'b0;
        end
        #HALF;
        if (raise_cs) begin
            cs = 1'b1;
            #(4*HALF);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},   64'(miso), 64'd0);
        check({tag, "_rval"},   64'(recv_val), 64'd0);
        check({tag, "_rmsg"},   64'(recv_msg), 64'd0);
        check({tag, "_srdy"},   64'(send_rdy), 64'd0);
        check({tag, "_parity"}, 64'(minion_parity), 64'd0);
        check({tag, "_ovf"},    64'(overflow), 64'd0);
    endtask

    initial begin
        logic [F-1:0] rx;
        int hs0, sr0;

        repeat (5) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Receive 0xDEADBEEF with interconnect ready.
        recv_rdy = 1'b1;
        hs0 = hs_cnt; sr0 = sr_cnt;
        spi_xfer({1'b1, 1'b1, 32'hDEADBEEF}, F, 1'b1, rx);
        check("rx_hs",     64'(hs_cnt - hs0), 64'd1);
        check("rx_msg",    64'(last_msg), 64'hDEADBEEF);
        check("rx_parity", 64'(minion_parity), 64'd0);
        check("rx_spc",    64'(rx[F-2]), 64'd1);
        check("rx_txval",  64'(rx[F-1]), 64'd0);
        check("rx_rval",   64'(recv_val), 64'd0);
        check("rx_nosr",   64'(sr_cnt - sr0), 64'd0);

        // Send 0x12345678, master has space.
        send_val = 1'b1;
        send_msg = 32'h12345678;
        hs0 = hs_cnt; sr0 = sr_cnt;
        spi_xfer({1'b0, 1'b1, 32'h0}, F, 1'b1, rx);
        check("tx_miso", 64'(rx), 64'({1'b1, 1'b1, 32'h12345678}));
        check("tx_sr",   64'(sr_cnt - sr0), 64'd1);
        check("tx_nohs", 64'(hs_cnt - hs0), 64'd0);

        // Master without space: no dequeue, then the same word again.
        sr0 = sr_cnt;
        spi_xfer({1'b0, 1'b0, 32'h0}, F, 1'b1, rx);
        check("blk_miso", 64'(rx), 64'({1'b1, 1'b1, 32'h12345678}));
        check("blk_sr",   64'(sr_cnt - sr0), 64'd0);
        sr0 = sr_cnt;
        spi_xfer({1'b0, 1'b1, 32'h0}, F, 1'b1, rx);
        check("rtry_miso", 64'(rx), 64'({1'b1, 1'b1, 32'h12345678}));
        check("rtry_sr",   64'(sr_cnt - sr0), 64'd1);
        send_val = 1'b0;

        // Overflow: buffer not drained between two valid frames.
        recv_rdy = 1'b0;
        spi_xfer({1'b1, 1'b1, 32'h1}, F, 1'b1, rx);
        check("ovf1_rval", 64'(recv_val), 64'd1);
        check("ovf1_ovf",  64'(overflow), 64'd0);
        spi_xfer({1'b1, 1'b1, 32'h2}, F, 1'b1, rx);
        check("ovf2_spc",    64'(rx[F-2]), 64'd0);
        check("ovf2_msg",    64'(recv_msg), 64'h1);
        check("ovf2_ovf",    64'(overflow), 64'd1);
        check("ovf2_parity", 64'(minion_parity), 64'd1);
        hs0 = hs_cnt;
        recv_rdy = 1'b1;
        repeat (4) @(negedge clk);
        check("ovf_drain_hs",  64'(hs_cnt - hs0), 64'd1);
        check("ovf_drain_msg", 64'(last_msg), 64'h1);

        // Framing error: cs released after 20 bits.
        send_val = 1'b1;
        send_msg = 32'h55;
        hs0 = hs_cnt; sr0 = sr_cnt;
        spi_xfer({1'b1, 1'b1, 32'hFFFFFFFF}, 20, 1'b1, rx);
        check("ferr_hs",   64'(hs_cnt - hs0), 64'd0);
        check("ferr_sr",   64'(sr_cnt - sr0), 64'd0);
        check("ferr_rval", 64'(recv_val), 64'd0);
`ifdef SPI_MINION_FRAME_ERR_CNT_EN
        check("ferr_cnt",  64'(frame_err_cnt), 64'd1);
`endif
        send_val = 1'b0;

        // Reset in the middle of a frame, then a clean frame.
        spi_xfer({1'b1, 1'b1, 32'h77777777}, 10, 1'b0, rx);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("midrst");
`ifdef SPI_MINION_FRAME_ERR_CNT_EN
        check("midrst_cnt", 64'(frame_err_cnt), 64'd0);
`endif
        reset = 1'b1;
        repeat (4) @(negedge clk);
        cs = 1'b1;
        #(4*HALF);
        hs0 = hs_cnt;
        spi_xfer({1'b1, 1'b1, 32'hCAFEF00D}, F, 1'b1, rx);
        check("post_hs",     64'(hs_cnt - hs0), 64'd1);
        check("post_msg",    64'(last_msg), 64'hCAFEF00D);
        check("post_parity", 64'(minion_parity), 64'd0);
        check("post_ovf",    64'(overflow), 64'd0);
        check("post_rval",   64'(recv_val), 64'd0);
`ifdef SPI_MINION_FRAME_ERR_CNT_EN
        check("post_cnt",    64'(frame_err_cnt), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
